datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Moore FSM that sequences the lab datapath (register file, shifter, ALU, status reg) for one
//  16-bit instruction per start handshake. Decodes MOV-imm, MOV-reg, ADD, CMP, AND and MVN.
//  Issues register read/write, A/B/C/status load enables, mux selects, shift and ALU_op codes.
//  Sits between the instruction source (switches / future fetch unit) and the datapath.
// PARAMETERS
//  W      16  datapath width; sximm8 is sign-extended to W
//  IMM_W   8  immediate field width (instr[IMM_W-1:0])
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request; sampled only in WAIT
//  instr      in   16  {opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0]}
//  waiting    out  1   1 only in WAIT (ready for start)
//  done       out  1   1-cycle pulse in an instruction's final state
//  illegal    out  1   1-cycle pulse, DECODE state, undefined encoding
//  r_addr     out  3   register file read address
//  w_addr     out  3   register file write address
//  w_en       out  1   register file write enable
//  en_A/en_B  out  1   load A / B operand registers
//  en_C       out  1   load result register C
//  en_status  out  1   load Z status register
//  sel_A      out  1   1 = ALU A input forced to 0
//  vsel       out  1   write-back source: 0 = C, 1 = sximm8
//  shift      out  2   shifter op (instr.sh; 00 outside EXEC)
//  ALU_op     out  2   00 add, 01 sub, 10 and, 11 not-B
//  sximm8     out  W   sign-extended instr_q[7:0]
// BEHAVIOUR
//  - rst (async): state=WAIT, instr_q=0; waiting=1, every other output 0 (sximm8=0).
//  - Outputs are functions of state + instr_q only (no combinational path from start/instr).
//  - WAIT: start=1 -> instr_q<=instr, go DECODE. start in other states ignored, instr not re-latched.
//  - DECODE: opcode/op select next state:
//      110/10 MOV Rn,#imm -> WR_IMM     110/00 MOV Rd,Rm{sh} -> GET_B
//      101/11 MVN Rd,Rm   -> GET_B      101/00,01,10 ADD/CMP/AND -> GET_A
//      anything else       -> WAIT, illegal=1, no enables, no done.
//  - WR_IMM: w_addr=Rn, vsel=1, w_en=1, done=1 -> WAIT.
//  - GET_A:  r_addr=Rn, en_A=1 -> GET_B.
//  - GET_B:  r_addr=Rm, en_B=1 -> EXEC.
//  - EXEC:   shift=sh; MOV-reg: ALU_op=00, sel_A=1; else ALU_op=op, sel_A=0.
//      CMP: en_status=1, en_C=0, done=1 -> WAIT. Others: en_C=1 -> WRITE.
//  - WRITE:  w_addr=Rd, vsel=0, w_en=1, done=1 -> WAIT.
//  - Latency start-sample to done state: MOV-imm 2, MOV-reg/MVN 4, CMP 4, ADD/AND 5 cycles; WAIT
//    resumes the cycle after done. Back-to-back: start held high re-issues immediately from WAIT.
//  - Unused addresses/selects are 0 outside their state; at most one of w_en/en_A/en_B/en_C/en_status
//    is high per cycle, except none in WAIT/DECODE.
//  - sximm8 = {{(W-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]}.
//  - rst asserted mid-instruction: immediate return to WAIT, no write/done issued afterwards.
// TESTING
//  1 MOV R0,#-5: instr=16'hD0FB,start 1 cycle -> DECODE,WR_IMM(w_en=1,w_addr=0,vsel=1,sximm8=16'hFFFB,done=1),WAIT.
//  2 ADD R2,R1,R0 LSL: instr=16'hA148 -> GET_A(r_addr=1,en_A), GET_B(r_addr=0,en_B),
//    EXEC(ALU_op=00,shift=01,en_C), WRITE(w_addr=2,w_en,done); 5 cycles start->done.
//  3 CMP R1,R0: 16'hA900 -> EXEC has ALU_op=01, en_status=1, en_C=0, done=1; w_en never asserted.
//  4 MVN R3,R0 16'hB860 -> skips GET_A, EXEC ALU_op=11; MOV R4,R1 16'hC081 -> EXEC sel_A=1, ALU_op=00, w_addr=4.
//  5 Illegal 16'hE000 -> DECODE pulses illegal=1, no enables, back to WAIT next cycle, waiting=1.
//  6 rst during EXEC of 16'hA148 -> same cycle waiting=1, all enables 0; after release no WRITE/done.

Source files
------------

// File: rtl/datapath_controller.sv
// Moore sequencer for the lab datapath: latches one 16-bit instruction per start handshake
// and steps the register file, shifter, ALU and status register through it.
module datapath_controller #(
    parameter int unsigned W     = 16,
    parameter int unsigned IMM_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  instr,
    output logic         waiting,
    output logic         done,
    output logic         illegal,
    output logic [2:0]   r_addr,
    output logic [2:0]   w_addr,
    output logic         w_en,
    output logic         en_A,
    output logic         en_B,
    output logic         en_C,
    output logic         en_status,
    output logic         sel_A,
    output logic         vsel,
    output logic [1:0]   shift,
    output logic [1:0]   ALU_op,
    output logic [W-1:0] sximm8
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WR_IMM = 3'd2;
    localparam logic [2:0] S_GET_A  = 3'd3;
    localparam logic [2:0] S_GET_B  = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    function automatic logic is_mov_imm(input logic [15:0] i);
        return (i[15:13] == OPC_MOV) && (i[12:11] == 2'b10);
    endfunction

    function automatic logic is_mov_reg(input logic [15:0] i);
        return (i[15:13] == OPC_MOV) && (i[12:11] == 2'b00);
    endfunction

    function automatic logic is_mvn(input logic [15:0] i);
        return (i[15:13] == OPC_ALU) && (i[12:11] == 2'b11);
    endfunction

    function automatic logic is_cmp(input logic [15:0] i);
        return (i[15:13] == OPC_ALU) && (i[12:11] == 2'b01);
    endfunction

    logic [2:0]   state_q, state_d;
    logic [15:0]  instr_q, instr_d;

    logic         waiting_q, waiting_d;
    logic         done_q, done_d;
    logic         illegal_q, illegal_d;
    logic [2:0]   r_addr_q, r_addr_d;
    logic [2:0]   w_addr_q, w_addr_d;
    logic         w_en_q, w_en_d;
    logic         en_a_q, en_a_d;
    logic         en_b_q, en_b_d;
    logic         en_c_q, en_c_d;
    logic         en_status_q, en_status_d;
    logic         sel_a_q, sel_a_d;
    logic         vsel_q, vsel_d;
    logic [1:0]   shift_q, shift_d;
    logic [1:0]   alu_op_q, alu_op_d;
    logic [W-1:0] sximm8_q, sximm8_d;

    // Next state and instruction latch
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm(instr_q))
                    state_d = S_WR_IMM;
                else if (is_mov_reg(instr_q) || is_mvn(instr_q))
                    state_d = S_GET_B;
                else if (instr_q[15:13] == OPC_ALU)
                    state_d = S_GET_A;
                else
                    state_d = S_WAIT;
            end
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp(instr_q) ? S_WAIT : S_WRITE;
            S_WRITE:  state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they can be registered with it
    always_comb begin
        waiting_d   = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        r_addr_d    = 3'd0;
        w_addr_d    = 3'd0;
        w_en_d      = 1'b0;
        en_a_d      = 1'b0;
        en_b_d      = 1'b0;
        en_c_d      = 1'b0;
        en_status_d = 1'b0;
        sel_a_d     = 1'b0;
        vsel_d      = 1'b0;
        shift_d     = 2'b00;
        alu_op_d    = 2'b00;
        sximm8_d    = {{(W-IMM_W){instr_d[IMM_W-1]}}, instr_d[IMM_W-1:0]};
        case (state_d)
            S_WAIT:   waiting_d = 1'b1;
            S_DECODE: illegal_d = !(is_mov_imm(instr_d) || is_mov_reg(instr_d) ||
                                    (instr_d[15:13] == OPC_ALU));
            S_WR_IMM: begin
                w_addr_d = instr_d[10:8];
                vsel_d   = 1'b1;
                w_en_d   = 1'b1;
                done_d   = 1'b1;
            end
            S_GET_A: begin
                r_addr_d = instr_d[10:8];
                en_a_d   = 1'b1;
            end
            S_GET_B: begin
                r_addr_d = instr_d[2:0];
                en_b_d   = 1'b1;
            end
            S_EXEC: begin
                shift_d = instr_d[4:3];
                if (instr_d[15:13] == OPC_MOV)
                    sel_a_d = 1'b1;
                else
                    alu_op_d = instr_d[12:11];
                if (is_cmp(instr_d)) begin
                    en_status_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    en_c_d = 1'b1;
                end
            end
            S_WRITE: begin
                w_addr_d = instr_d[7:5];
                w_en_d   = 1'b1;
                done_d   = 1'b1;
            end
            default: waiting_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            instr_q     <= 16'd0;
            waiting_q   <= 1'b1;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            r_addr_q    <= 3'd0;
            w_addr_q    <= 3'd0;
            w_en_q      <= 1'b0;
            en_a_q      <= 1'b0;
            en_b_q      <= 1'b0;
            en_c_q      <= 1'b0;
            en_status_q <= 1'b0;
            sel_a_q     <= 1'b0;
            vsel_q      <= 1'b0;
            shift_q     <= 2'b00;
            alu_op_q    <= 2'b00;
            sximm8_q    <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            waiting_q   <= waiting_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            r_addr_q    <= r_addr_d;
            w_addr_q    <= w_addr_d;
            w_en_q      <= w_en_d;
            en_a_q      <= en_a_d;
            en_b_q      <= en_b_d;
            en_c_q      <= en_c_d;
            en_status_q <= en_status_d;
            sel_a_q     <= sel_a_d;
            vsel_q      <= vsel_d;
            shift_q     <= shift_d;
            alu_op_q    <= alu_op_d;
            sximm8_q    <= sximm8_d;
        end
    end

    assign waiting   = waiting_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign r_addr    = r_addr_q;
    assign w_addr    = w_addr_q;
    assign w_en      = w_en_q;
    assign en_A      = en_a_q;
    assign en_B      = en_b_q;
    assign en_C      = en_c_q;
    assign en_status = en_status_q;
    assign sel_A     = sel_a_q;
    assign vsel      = vsel_q;
    assign shift     = shift_q;
    assign ALU_op    = alu_op_q;
    assign sximm8    = sximm8_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: a per-cycle expected-output scoreboard is filled from an
// instruction-level model when start is driven and drained as the controller steps.
module tb_datapath_controller;

    typedef struct packed {
        logic        waiting;
        logic        done;
        logic        illegal;
        logic [2:0]  r_addr;
        logic [2:0]  w_addr;
        logic        w_en;
        logic        en_a;
        logic        en_b;
        logic        en_c;
        logic        en_status;
        logic        sel_a;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        waiting, done, illegal, w_en, en_A, en_B, en_C, en_status, sel_A, vsel;
    logic [2:0]  r_addr, w_addr;
    logic [1:0]  shift, ALU_op;
    logic [15:0] sximm8;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    datapath_controller #(.W(16), .IMM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .waiting(waiting), .done(done), .illegal(illegal),
        .r_addr(r_addr), .w_addr(w_addr), .w_en(w_en),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .sel_A(sel_A), .vsel(vsel), .shift(shift), .ALU_op(ALU_op), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = '{waiting, done, illegal, r_addr, w_addr, w_en, en_A, en_B, en_C,
              en_status, sel_A, vsel, shift, ALU_op, sximm8};
        return o;
    endfunction

    // Instruction-level model: one expected vector per cycle from DECODE through the return to WAIT
    task automatic push_model(input logic [15:0] ins);
        obs_t       b, v;
        logic [2:0] opc = ins[15:13];
        logic [1:0] op  = ins[12:11];
        logic       mov_imm = (opc == 3'b110) && (op == 2'b10);
        logic       mov_reg = (opc == 3'b110) && (op == 2'b00);
        logic       alu     = (opc == 3'b101);
        logic       cmp     = alu && (op == 2'b01);
        b = '0;
        b.sximm8 = {{8{ins[7]}}, ins[7:0]};
        v = b; v.illegal = !(mov_imm || mov_reg || alu); exp_q.push_back(v);
        if (mov_imm) begin
            v = b; v.w_addr = ins[10:8]; v.vsel = 1'b1; v.w_en = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (mov_reg || alu) begin
            if (alu && op != 2'b11) begin
                v = b; v.r_addr = ins[10:8]; v.en_a = 1'b1; exp_q.push_back(v);
            end
            v = b; v.r_addr = ins[2:0]; v.en_b = 1'b1; exp_q.push_back(v);
            v = b; v.shift = ins[4:3];
            if (mov_reg) v.sel_a = 1'b1; else v.alu_op = op;
            if (cmp) begin v.en_status = 1'b1; v.done = 1'b1; end else v.en_c = 1'b1;
            exp_q.push_back(v);
            if (!cmp) begin
                v = b; v.w_addr = ins[7:5]; v.w_en = 1'b1; v.done = 1'b1; exp_q.push_back(v);
            end
        end
        v = '0; v.waiting = 1'b1; v.sximm8 = b.sximm8; exp_q.push_back(v);
    endtask

    // Present one instruction in WAIT; returns at the first cycle after the sampling edge
    task automatic issue(input logic [15:0] ins, input logic hold);
        start = 1'b1;
        instr = ins;
        push_model(ins);
        @(posedge clk); #1;
        start = hold;
        instr = 16'($urandom);
    endtask

    task automatic test_reset();
        obs_t rv;
        rv = '0; rv.waiting = 1'b1;
        rst = 1'b1; start = 1'b1; instr = 16'hD0FB;
        #1;
        checks++;
        if (sample() !== rv) begin errors++; $display("FAIL reset_async got %h exp %h", sample(), rv); end
        @(posedge clk); #1;
        checks++;
        if (sample() !== rv) begin errors++; $display("FAIL reset_held got %h exp %h", sample(), rv); end
        start = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sample() !== rv) begin errors++; $display("FAIL reset_release got %h exp %h", sample(), rv); end
    endtask

    task automatic test_single(input string name, input logic [15:0] ins, input int exp_lat);
        obs_t e, o;
        int   cyc = 1, lat = -1;
        logic saw_w_en = 1'b0, saw_illegal = 1'b0;
        issue(ins, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = sample();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s cyc%0d got %h exp %h", name, cyc, o, e); end
            if (o.done && lat < 0) lat = cyc;
            saw_w_en    |= o.w_en;
            saw_illegal |= o.illegal;
            if (exp_q.size() > 0) begin @(posedge clk); #1; cyc++; end
        end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, exp_lat); end
        if (ins == 16'hA900) begin
            checks++;
            if (saw_w_en) begin errors++; $display("FAIL cmp_no_write got w_en=1 exp 0"); end
        end
        if (ins == 16'hE000) begin
            checks++;
            if (!saw_illegal) begin errors++; $display("FAIL illegal_pulse got 0 exp 1"); end
        end
    endtask

    // start stays high: ignored mid-instruction, and re-issues straight out of WAIT
    task automatic test_back_to_back();
        logic [15:0] seq [4] = '{16'hC081, 16'hA148, 16'hB860, 16'hD085};
        obs_t e, o;
        for (int k = 0; k < 4; k++) begin
            int cyc = 1;
            issue(seq[k], k < 3);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); o = sample();
                checks++;
                if (o !== e) begin
                    errors++; $display("FAIL b2b_%0d cyc%0d got %h exp %h", k, cyc, o, e);
                end
                if (exp_q.size() > 0) begin @(posedge clk); #1; cyc++; end
            end
        end
    endtask

    task automatic test_rst_mid();
        obs_t e, o, rv;
        rv = '0; rv.waiting = 1'b1;
        issue(16'hA148, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            e = exp_q.pop_front(); o = sample();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_pre cyc%0d got %h exp %h", c, o, e); end
            if (c < 4) begin @(posedge clk); #1; end
        end
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sample() !== rv) begin errors++; $display("FAIL rstmid_async got %h exp %h", sample(), rv); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (sample() !== rv) begin errors++; $display("FAIL rstmid_after cyc%0d got %h exp %h", c, sample(), rv); end
        end
    endtask

    initial begin
        test_reset();
        test_single("mov_imm", 16'hD0FB, 2);
        test_single("add",     16'hA148, 5);
        test_single("cmp",     16'hA900, 4);
        test_single("mvn",     16'hB860, 4);
        test_single("mov_reg", 16'hC081, 4);
        test_single("and",     16'hB2E9, 5);
        test_single("illegal", 16'hE000, -1);
        test_single("mov_pos", 16'hD37F, 2);
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
